// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared constants and types for the frame-buffer arbiter
package fb_arb_pkg;

    // Requester slots on the arbiter ports
    localparam int REQ_CAM  = 0;
    localparam int REQ_VGA  = 1;
    localparam int REQ_CONV = 2;

    // One 640x480 RGB565 frame, one word per pixel
    localparam int FRAME_WORDS = 640 * 480;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner select
module rr_priority_pick #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the slot after the last winner, wrapping, first hit wins
    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - burst arbiter for the shared single-port frame buffer
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = fb_arb_pkg::FRAME_WORDS,
    parameter int MAX_URGENT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic                      urgent,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        beat,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(BURST_LEN);
    localparam int UW = $clog2(MAX_URGENT + 1);

    state_t               state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr_ptr;
    logic [UW-1:0]        urg_cnt;
    logic [ADDR_W-1:0]    addr_cnt;
    logic                 we_lat;
    logic [BW-1:0]        beat_cnt;
    logic [NUM_REQ-1:0]   rvalid_q;

    logic                 urg_ok;
    logic                 guard;
    logic [NUM_REQ-1:0]   rr_req;
    logic [NUM_REQ-1:0]   rr_onehot;
    logic [IW-1:0]        rr_idx;
    logic                 rr_any;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [IW-1:0]        win_idx;

    // Urgent camera wins outright until it has used up its consecutive quota
    assign urg_ok = req[REQ_CAM] & urgent & (urg_cnt < UW'(MAX_URGENT));
    assign guard  = req[REQ_CAM] & urgent & ~urg_ok;

    // Once the quota is spent, hand the slot to someone else if anyone waits
    always_comb begin
        rr_req = req;
        if (guard && (req & ~NUM_REQ'(1)) != '0) begin
            rr_req[REQ_CAM] = 1'b0;
        end
    end

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .req    (rr_req),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    assign win_onehot = urg_ok ? NUM_REQ'(1) : rr_onehot;
    assign win_idx    = urg_ok ? IW'(REQ_CAM) : rr_idx;

    // Burst-phase outputs are pure decodes of the latched burst context
    assign busy      = (state == BURST);
    assign gnt       = busy ? (NUM_REQ'(1) << owner) : '0;
    assign beat      = gnt;
    assign mem_en    = busy;
    assign mem_we    = busy & we_lat;
    assign mem_addr  = busy ? addr_cnt : '0;
    assign mem_wdata = busy ? req_wdata[owner*DATA_W +: DATA_W] : '0;
    assign rvalid    = rvalid_q;
    assign rdata     = mem_rdata;

    // Arbitration in IDLE, beat sequencing in BURST, read-valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            urg_cnt  <= '0;
            addr_cnt <= '0;
            we_lat   <= 1'b0;
            beat_cnt <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= beat & {NUM_REQ{~we_lat}};
            case (state)
                IDLE: begin
                    if (urg_ok || rr_any) begin
                        state    <= BURST;
                        owner    <= win_idx;
                        addr_cnt <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        we_lat   <= |(win_onehot & req_we);
                        beat_cnt <= '0;
                        if (urg_ok) begin
                            urg_cnt <= urg_cnt + 1'b1;
                        end else begin
                            rr_ptr  <= rr_idx;
                            urg_cnt <= '0;
                        end
                    end
                end
                BURST: begin
                    addr_cnt <= (addr_cnt == ADDR_W'(FRAME_WORDS - 1)) ? '0 : addr_cnt + 1'b1;
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == BW'(BURST_LEN - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - self-checking bench for frame_buffer_arbiter
module tb_frame_buffer_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BL = 16;
    localparam int FW = 307200;
    localparam int MU = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic            urgent;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, beat, rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    frame_buffer_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
        .FRAME_WORDS(FW), .MAX_URGENT(MU)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .urgent(urgent), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .beat(beat),
        .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a * 7 + 3) ^ 16'h5A3C;
    endfunction

    // RAM model: 1-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= pat(mem_addr);
    end

    // Requester write-data sources: each advances on its own beat
    logic [DW-1:0] wd [N];
    initial for (int i = 0; i < N; i++) wd[i] = DW'(16'h1000 * (i + 1));
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) if (beat[i] === 1'b1) wd[i] <= wd[i] + 16'h0101;
    end
    assign req_wdata = {wd[2], wd[1], wd[0]};

    // Read-return monitor: rvalid must echo the previous cycle's read beat
    logic          mon_en = 1'b0;
    logic [N-1:0]  p_beat = '0;
    logic          p_rd = 1'b0, p_rst = 1'b1;
    logic [AW-1:0] p_addr = '0;
    int            rv_cnt [N];
    initial for (int i = 0; i < N; i++) rv_cnt[i] = 0;
    always @(negedge clk) begin
        logic [N-1:0] exp_rv;
        if (mon_en) begin
            exp_rv = (p_rst || !p_rd) ? '0 : p_beat;
            vectors++;
            if (rvalid !== exp_rv) begin
                errors++;
                $display("FAIL rvalid_timing t=%0d got %b want %b", cyc, rvalid, exp_rv);
            end
            if (exp_rv != '0 && rdata !== pat(p_addr)) begin
                errors++;
                $display("FAIL rdata t=%0d got %h want %h", cyc, rdata, pat(p_addr));
            end
            for (int i = 0; i < N; i++) if (rvalid[i] === 1'b1) rv_cnt[i]++;
        end
        p_beat = beat;
        p_rd   = (mem_en === 1'b1) && (mem_we === 1'b0);
        p_rst  = reset;
        p_addr = mem_addr;
    end

    // Arbitration reference model
    int m_rr = 0, m_urg = 0;
    function automatic int model_pick(input logic [N-1:0] r, input logic u);
        logic [N-1:0] cand;
        if (r[0] && u && m_urg < MU) begin
            m_urg++;
            return 0;
        end
        cand = r;
        if (r[0] && u && (r[1] || r[2])) cand[0] = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (cand[j]) begin
                m_rr  = j;
                m_urg = 0;
                return j;
            end
        end
        return -1;
    endfunction

    // Burst observation (no checks here; the tests compare)
    int            o_ok, o_len, o_owner, o_start, o_bad;
    logic [AW-1:0] o_addr [40];
    logic          o_we   [40];
    logic [DW-1:0] o_wd   [40];

    task automatic wait_burst();
        int t = 0;
        logic [N-1:0] g0;
        o_ok = 1; o_len = 0; o_owner = -1; o_bad = 0;
        while (busy !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b1) begin
            o_ok = 0;
            return;
        end
        o_start = cyc;
        g0 = gnt;
        for (int i = 0; i < N; i++) if (g0 == N'(1 << i)) o_owner = i;
        while (busy === 1'b1 && o_len < 40) begin
            if (gnt !== g0 || beat !== g0 || mem_en !== 1'b1) o_bad = 1;
            if (mem_we === 1'b1 && o_owner >= 0 && mem_wdata !== wd[o_owner]) o_bad = 1;
            o_addr[o_len] = mem_addr;
            o_we[o_len]   = mem_we;
            o_wd[o_len]   = mem_wdata;
            o_len++;
            @(negedge clk);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; urgent = 1'b0; req_we = '0; req_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_rr = 0; m_urg = 0;
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({gnt, beat, rvalid, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b beat=%b rv=%b en=%b busy=%b want all 0",
                     gnt, beat, rvalid, mem_en, busy);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b gnt=%b want 0", busy, gnt);
        end
    endtask

    task automatic test_single_read();
        int bad = 0;
        int c0;
        do_reset();
        set_req(1, 1'b0, AW'(100));
        req = 3'b010;
        c0 = rv_cnt[1];
        wait_burst();
        req = '0;
        vectors++;
        if (!o_ok || o_owner != 1 || o_len != BL || o_bad) begin
            errors++;
            $display("FAIL single_read_burst got ok=%0d owner=%0d len=%0d bad=%0d want 1/1/16/0",
                     o_ok, o_owner, o_len, o_bad);
        end
        for (int k = 0; k < BL; k++)
            if (o_addr[k] !== AW'(100 + k) || o_we[k] !== 1'b0) bad++;
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_read_addr got %0d wrong beats want 0", bad);
        end
        vectors++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL gap_after_burst got gnt=%b want 000", gnt);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (rv_cnt[1] - c0 != BL) begin
            errors++;
            $display("FAIL single_read_rvalid_count got %0d want %0d", rv_cnt[1] - c0, BL);
        end
    endtask

    task automatic test_round_robin();
        int exp_o [6] = '{1, 2, 0, 1, 2, 0};
        int last = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 1000));
        req = 3'b111;
        for (int b = 0; b < 6; b++) begin
            wait_burst();
            vectors++;
            if (!o_ok || o_owner != exp_o[b] || o_owner != model_pick(3'b111, 1'b0)) begin
                errors++;
                $display("FAIL rr_owner[%0d] got %0d want %0d", b, o_owner, exp_o[b]);
            end
            if (b > 0) begin
                vectors++;
                if (o_start - last != BL + 1) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d] got %0d want %0d", b, o_start - last, BL + 1);
                end
            end
            last = o_start;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_starvation();
        int exp_o [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 2000));
        req = 3'b111;
        urgent = 1'b1;
        for (int b = 0; b < 10; b++) begin
            wait_burst();
            vectors++;
            if (!o_ok || o_owner != exp_o[b] || o_owner != model_pick(3'b111, 1'b1)) begin
                errors++;
                $display("FAIL starve_owner[%0d] got %0d want %0d", b, o_owner, exp_o[b]);
            end
        end
        req = '0;
        urgent = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        int bad = 0;
        logic [DW-1:0] d0;
        do_reset();
        set_req(0, 1'b1, AW'(307192));
        d0 = wd[0];
        req = 3'b001;
        wait_burst();
        req = '0;
        vectors++;
        if (!o_ok || o_owner != 0 || o_len != BL || o_bad) begin
            errors++;
            $display("FAIL wrap_burst got ok=%0d owner=%0d len=%0d bad=%0d want 1/0/16/0",
                     o_ok, o_owner, o_len, o_bad);
        end
        for (int k = 0; k < BL; k++) begin
            logic [AW-1:0] ea;
            ea = (k < 8) ? AW'(307192 + k) : AW'(k - 8);
            if (o_addr[k] !== ea || o_we[k] !== 1'b1 || o_wd[k] !== DW'(d0 + k * 16'h0101)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_addr_data got %0d wrong beats want 0", bad);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_and_reset();
        int n = 0, t = 0;
        do_reset();
        set_req(2, 1'b0, AW'(5000));
        req = 3'b100;
        while (busy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        while (busy === 1'b1 && n < 40) begin
            if (beat === 3'b100) n++;
            if (n == 4) req = '0;
            @(negedge clk);
        end
        vectors++;
        if (n != BL) begin
            errors++;
            $display("FAIL drop_beats got %0d want %0d", n, BL);
        end
        repeat (2) @(negedge clk);
        set_req(1, 1'b0, AW'(7000));
        req = 3'b010;
        n = 0; t = 0;
        while (busy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        while (busy === 1'b1 && n < 8) begin @(negedge clk); n++; end
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        vectors++;
        if (n != 8 || gnt !== '0 || mem_en !== 1'b0 || rvalid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst got n=%0d gnt=%b en=%b rv=%b busy=%b want 8/000/0/000/0",
                     n, gnt, mem_en, rvalid, busy);
        end
        reset = 1'b0;
        m_rr = 0; m_urg = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int b = 0; b < 30; b++) begin
            logic [N-1:0]  r;
            logic          u;
            logic          we [N];
            logic [AW-1:0] ba [N];
            int            exp_own, bad;
            r = N'($urandom_range(1, 7));
            u = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                we[i] = 1'($urandom_range(0, 1));
                ba[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(FW - 20, FW - 1))
                                                    : AW'($urandom_range(0, FW - 1));
                set_req(i, we[i], ba[i]);
            end
            req = r;
            urgent = u;
            exp_own = model_pick(r, u);
            wait_burst();
            vectors++;
            if (!o_ok || o_owner != exp_own || o_len != BL || o_bad) begin
                errors++;
                $display("FAIL rand_owner[%0d] got owner=%0d len=%0d bad=%0d want owner=%0d len=16",
                         b, o_owner, o_len, o_bad, exp_own);
            end else begin
                logic [AW-1:0] ea;
                bad = 0;
                ea = ba[exp_own];
                for (int k = 0; k < BL; k++) begin
                    if (o_addr[k] !== ea || o_we[k] !== we[exp_own]) bad++;
                    ea = (ea == AW'(FW - 1)) ? '0 : ea + 1'b1;
                end
                vectors++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand_addr[%0d] got %0d wrong beats want 0", b, bad);
                end
            end
        end
        req = '0;
        urgent = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_wrap();
        test_drop_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
